// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and sizes for the program loader
package loader_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;

  localparam logic [DATA_W-1:0] DEFAULT_FILL_WORD = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_CLEAR,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - 256x8 program store, one synchronous write port, one asynchronous read port
module inst_mem
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read bypasses nothing: a same-cycle write shows up only after the edge.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program into instruction memory and holds the CPU until it is complete
// Optional trailing checksum byte and ERR state: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [DATA_W-1:0] FILL_WORD = DEFAULT_FILL_WORD,
  parameter int                RESET_RUN = 0
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] INST,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              loading,
  output logic              load_done,
  output logic              load_err
);

  localparam state_e RESET_STATE = (RESET_RUN != 0) ? ST_RUN : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic              done_q, done_d;
  logic              hold_q, hold_d;
  logic              loading_q, loading_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  logic              accept;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  assign load_ready = rdy_q & ~load_start;
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    len_d     = len_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = load_data;

    if (load_start) begin
      state_d = ST_LEN;
      addr_d  = '0;
      sum_d   = '0;
    end else begin
      case (state_q)
        ST_LEN: begin
          if (accept) begin
            len_d   = load_data;
            sum_d   = load_data;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            mem_we = 1'b1;
            sum_d  = sum_q + load_data;
            addr_d = addr_q + 8'd1;
            // len_q of 0 wraps to 255 here, giving a 256-byte image.
            if (addr_q == len_q - 8'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = (addr_d == '0) ? ST_RUN : ST_CLEAR;
              done_d  = (addr_d == '0);
`endif
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            sum_d = sum_q + load_data;
            if (sum_d == '0) begin
              state_d = (addr_q == '0) ? ST_RUN : ST_CLEAR;
              done_d  = (addr_q == '0);
            end else begin
              state_d = ST_ERR;
            end
          end
        end
`endif
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_wdata = FILL_WORD;
          addr_d    = addr_q + 8'd1;
          if (addr_q == 8'hFF) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    hold_d    = (state_d != ST_RUN);
    loading_d = (state_d == ST_LEN) || (state_d == ST_DATA) ||
                (state_d == ST_CHK) || (state_d == ST_CLEAR);
    rdy_d     = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    err_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q   <= RESET_STATE;
      addr_q    <= '0;
      sum_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      hold_q    <= (RESET_STATE != ST_RUN);
      loading_q <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      len_q     <= len_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
      loading_q <= loading_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  assign cpu_hold  = hold_q;
  assign loading   = loading_q;
  assign load_done = done_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  // Reset must leave memory untouched, including a CLEAR write in flight.
  inst_mem u_inst_mem (
    .clk   (clk),
    .we    (mem_we & ~CLB),
    .waddr (addr_q),
    .wdata (mem_wdata),
    .raddr (PC),
    .rdata (INST)
  );

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Instruction-memory stage directly upstream of the 8-bit processor: holds a 256x8 program and returns INST for the processor's PC every cycle.
- Owns a byte-stream load port: a program is streamed in through a valid/ready handshake while the processor is held cleared.
- The processor is released (cpu_hold low) only after a complete, consistent image is in memory.

Parameters:
- FILL_WORD, 8'h00, value written to every address at or above the loaded length during the clear phase.
- RESET_RUN, 0, 1 = reset enters RUN directly using current memory contents; 0 = reset enters IDLE with the processor held.

Ports:
- clk  input  1  system clock, all state on rising edge.
- CLB  input  1  synchronous active-high reset.
- PC  input  8  fetch address from the processor.
- INST  output  8  mem[PC], combinational read, 0-cycle latency.
- load_start  input  1  one-cycle request to begin a new load.
- load_data  input  8  stream byte.
- load_valid  input  1  load_data valid.
- load_ready  output  1  block accepts a byte this cycle (accept = load_valid & load_ready).
- cpu_hold  output  1  high = processor must be held cleared.
- loading  output  1  high in LEN, DATA, CHK, CLEAR.
- load_done  output  1  one-cycle pulse on entry to RUN from a load.
- load_err  output  1  high in ERR state.

Behaviour:
- States: IDLE, LEN, DATA, CHK, CLEAR, RUN, ERR. CLB high -> state = RESET_RUN ? RUN : IDLE; addr = 0; sum = 0; load_done = 0.
- Memory contents are not affected by CLB.
- cpu_hold = 1 in every state except RUN. load_err = 1 only in ERR.
- load_ready = (state is LEN, DATA or CHK) & !load_start.
- load_start = 1 in any state: next state LEN, addr = 0, sum = 0. It has priority over any byte in the same cycle; that byte is not accepted.
- LEN: the accepted byte sets len = byte (0 means 256) and sum = byte. Next state DATA.
- DATA: each accepted byte writes mem[addr] = byte, sum += byte (mod 256), addr++.
  - On accepting byte number len: go to CHK if checksum is enabled, else to post-data.
- Post-data:
  - len = 256 (addr wrapped to 0): go to RUN.
  - Otherwise: go to CLEAR.
- CLEAR: load_ready = 0. Writes FILL_WORD to mem[addr], one address per cycle, addr++. After writing address 255, go to RUN.
  - Takes 256 - len cycles.
- RUN: cpu_hold = 0. load_done is high for exactly the first RUN cycle after a load; it does not pulse on reset entry.
- Write and read of the same address in the same cycle: INST shows the old value until the edge.
- load_valid without load_ready is ignored, with no side effect.
- Stall tolerance: a source may hold load_valid low for any number of cycles in LEN, DATA or CHK. State is retained and there is no timeout.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state CHK accepts one checksum byte; sum += byte.
  - If sum == 8'h00, go to post-data (CLEAR/RUN).
  - Otherwise go to ERR. In ERR: cpu_hold = 1, load_err = 1, load_ready = 0; exit only via load_start or CLB.
  - Memory keeps the written data bytes.
- Undefined: CHK and ERR are unreachable, load_err is tied 0, and no checksum byte is consumed.

Decomposition:
- Shared package loader_pkg holds:
  - state enum (IDLE, LEN, DATA, CHK, CLEAR, RUN, ERR)
  - ADDR_W = 8, DATA_W = 8, MEM_DEPTH = 256
  - default FILL_WORD
- One sub-module, inst_mem: 256x8 array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr = PC, rdata = INST).
- The FSM, address counter and checksum accumulator stay in program_loader.

Test Plan:
- CLB=1 for 2 cycles with RESET_RUN=0 -> cpu_hold=1, load_ready=0, loading=0, load_done=0, load_err=0.
- Load without checksum: load_start, then bytes 04, A1, B2, C3, D4 back-to-back -> mem[0..3]=A1,B2,C3,D4; mem[4..255]=FILL_WORD after 252 CLEAR cycles; load_done pulses once; cpu_hold falls that same cycle; PC=02 gives INST=C3.
- Length 00 with 256 bytes 00..FF, valid toggling every other cycle -> no CLEAR cycles, RUN directly after the 256th byte, mem[k]=k, accepts = 257.
- load_start during DATA after 2 of 4 bytes, with load_valid=1 in that cycle -> the byte is not accepted, state is LEN, addr=0; a fresh 03,11,22,33 load completes normally.
- CHECKSUM_EN, bytes 02, 10, 20, checksum CE (sum 00) -> RUN and load_done. Same stream with checksum CF -> ERR, load_err=1, cpu_hold=1; a following load_start clears load_err next cycle.
- Reset mid-CLEAR (CLB at addr 80) -> IDLE with cpu_hold=1; mem[0..7F] keep their written values.
